// File: rtl/game_sequencer.sv
// game_sequencer
//   Top-level play controller for the note engine. Owns the beat timebase
//   (game_frame), judges key presses against the engine's current note,
//   keeps score/miss counts and runs the IDLE/PLAY/PAUSED/DONE game flow.
//
// Ports
//   game_clock  : the only clock
//   reset       : synchronous, active-high
//   start       : one-cycle pulse, begins or restarts a game
//   pause       : one-cycle pulse, toggles PLAY/PAUSED
//   key_press   : debounced key levels, bit k = key k
//   curr_note   : engine one-hot current note (0 = rest)
//   hold_length : engine beat length of the current note
//   game_frame  : beat counter fed to the engine
//   state       : 0=IDLE 1=PLAY 2=PAUSED 3=DONE
//   score       : accumulated score, saturating at 1023
//   misses      : miss count, saturating at 15
//   hit_pulse   : one cycle per judged hit
//   miss_pulse  : one cycle per judged miss
//   won         : valid in DONE, 1 = song completed
module game_sequencer #(
  parameter int TICKS_PER_BEAT = 16,
  parameter int SONG_BEATS     = 66,
  parameter int MAX_MISSES     = 3
) (
  input  logic        game_clock,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic [11:0] key_press,
  input  logic [11:0] curr_note,
  input  logic [3:0]  hold_length,
  output logic [7:0]  game_frame,
  output logic [1:0]  state,
  output logic [9:0]  score,
  output logic [3:0]  misses,
  output logic        hit_pulse,
  output logic        miss_pulse,
  output logic        won
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] PLAY   = 2'd1;
  localparam logic [1:0] PAUSED = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [15:0] TICK_LAST  = 16'(TICKS_PER_BEAT - 1);
  localparam logic [7:0]  SONG_END   = 8'(SONG_BEATS);
  localparam logic [3:0]  MISS_LIMIT = 4'(MAX_MISSES);

  logic [15:0] tick_count;
  logic [11:0] key_prev;
  logic [11:0] note_reg;
  logic [3:0]  note_len;
  logic [3:0]  note_beats;
  logic        hit_done;
  logic        window_open;
  // Counts down to the note load; 3 is set on the scheduling edge so the
  // load samples the engine two cycles after the new frame becomes visible.
  logic [1:0]  load_count;

  logic [11:0] press;
  logic        frame_step;
  logic        judge;
  logic        press_hit;
  logic        press_miss;
  logic        closing;
  logic        close_miss;
  logic [10:0] score_sum;
  logic [9:0]  score_next;
  logic [3:0]  misses_next;
  logic [3:0]  hold_eff;

  assign press       = key_press & ~key_prev;
  assign frame_step  = (tick_count == TICK_LAST);
  assign judge       = window_open && (press != 12'd0) && !hit_done;
  assign press_hit   = judge && (note_reg != 12'd0) && (press == note_reg);
  assign press_miss  = judge && !press_hit;
  // Window closes on the frame step that takes note_beats from 1 to 0; a hit
  // judged on that same edge suppresses the close miss.
  assign closing     = frame_step && window_open && (note_beats == 4'd1);
  assign close_miss  = closing && (note_reg != 12'd0) && !hit_done && !press_hit;
  assign score_sum   = {1'b0, score} + {7'd0, note_len};
  assign score_next  = (score_sum > 11'd1023) ? 10'h3FF : score_sum[9:0];
  assign misses_next = (misses == 4'hF) ? misses : misses + 4'd1;
  assign hold_eff    = (hold_length == 4'd0) ? 4'd1 : hold_length;

  // Game flow, timebase and judging. start outranks everything but reset;
  // inside PLAY the end-of-game check outranks pause and normal play.
  always_ff @(posedge game_clock) begin
    if (reset) begin
      state       <= IDLE;
      game_frame  <= 8'd0;
      score       <= 10'd0;
      misses      <= 4'd0;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
      won         <= 1'b0;
      tick_count  <= 16'd0;
      key_prev    <= 12'd0;
      note_reg    <= 12'd0;
      note_len    <= 4'd0;
      note_beats  <= 4'd0;
      hit_done    <= 1'b0;
      window_open <= 1'b0;
      load_count  <= 2'd0;
    end else begin
      // Key history tracks in every state so a key held across pause or
      // restart is never seen as a new press.
      key_prev   <= key_press;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      if (start) begin
        state       <= PLAY;
        game_frame  <= 8'd0;
        score       <= 10'd0;
        misses      <= 4'd0;
        won         <= 1'b0;
        tick_count  <= 16'd0;
        note_reg    <= 12'd0;
        note_beats  <= 4'd0;
        hit_done    <= 1'b0;
        window_open <= 1'b0;
        load_count  <= 2'd3;
      end else begin
        case (state)
          PLAY: begin
            if (misses >= MISS_LIMIT) begin
              state <= DONE;
              won   <= 1'b0;
            end else if (game_frame >= SONG_END) begin
              state <= DONE;
              won   <= 1'b1;
            end else if (pause) begin
              state <= PAUSED;
            end else begin
              tick_count <= frame_step ? 16'd0 : tick_count + 16'd1;
              if (frame_step && (game_frame != 8'hFF))
                game_frame <= game_frame + 8'd1;
              if (press_hit) begin
                score     <= score_next;
                hit_done  <= 1'b1;
                hit_pulse <= 1'b1;
              end
              if (press_miss || close_miss) begin
                misses     <= misses_next;
                miss_pulse <= 1'b1;
              end
              if (frame_step && window_open) begin
                note_beats <= note_beats - 4'd1;
                if (closing) begin
                  window_open <= 1'b0;
                  load_count  <= 2'd3;
                end
              end
              // A load can never coincide with a close: the load lands three
              // cycles after the close and a beat is at least four cycles.
              if (load_count == 2'd1) begin
                note_reg    <= curr_note;
                note_len    <= hold_eff;
                note_beats  <= hold_eff;
                hit_done    <= 1'b0;
                window_open <= 1'b1;
                load_count  <= 2'd0;
              end else if (load_count != 2'd0) begin
                load_count <= load_count - 2'd1;
              end
            end
          end
          PAUSED: begin
            if (pause)
              state <= PLAY;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level play controller for the note engine. It owns the beat timebase and drives `game_frame` into the engine. It judges player key presses against the engine's `curr_note`/`hold_length`, accumulating score and misses. It runs the IDLE/PLAY/PAUSED/DONE game flow that the display and audio blocks key off.

## Interface
Parameters:
- `TICKS_PER_BEAT`, default 16: `game_clock` cycles per beat; legal range 4..65535.
- `SONG_BEATS`, default 66: `game_frame` value at which the song ends; legal range 1..255.
- `MAX_MISSES`, default 3: miss count that ends the game as lost; legal range 1..15.

Ports:
- `game_clock`, in, 1: the only clock.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: one-cycle pulse that begins or restarts a game.
- `pause`, in, 1: one-cycle pulse that toggles PLAY/PAUSED.
- `key_press`, in, 12: debounced key levels, bit k = key k.
- `curr_note`, in, 12: engine one-hot current note; 0 = rest.
- `hold_length`, in, 4: engine beat length of the current note.
- `game_frame`, out, 8: beat counter fed to the engine.
- `state`, out, 2: 0=IDLE, 1=PLAY, 2=PAUSED, 3=DONE.
- `score`, out, 10: accumulated score, saturating.
- `misses`, out, 4: miss count.
- `hit_pulse`, out, 1: one cycle per judged hit.
- `miss_pulse`, out, 1: one cycle per judged miss.
- `won`, out, 1: valid in DONE; 1 = song completed.

## Operation
- Reset: `state`=IDLE, and `game_frame`, `score`, `misses`, `hit_pulse`, `miss_pulse`, `won`, tick counter and all internal flags = 0.
- IDLE: the timebase is frozen at `game_frame`=0.
  - `start` → PLAY. It clears `score`, `misses`, `won`, tick counter and `game_frame`, and schedules a note load.
- PLAY: the tick counter runs 0..`TICKS_PER_BEAT`-1.
  - On its wrap, `game_frame` increments, saturating at 255.
  - `pause` → PAUSED.
  - `start` restarts, with the same clearing as from IDLE.
- PAUSED: tick counter, `game_frame`, note counter and any pending load are all frozen.
  - Key edges are not judged, but the key history register still updates, so a key held across resume is not a new press.
  - `pause` → PLAY.
  - `start` restarts.
- DONE: all outputs hold.
  - `start` restarts.
  - `pause` is ignored.
- `start` and `pause` asserted in the same cycle: `start` wins.
- Note tracking uses `note_beats` (4 bits) and `hit_done`.
  - A note load samples `curr_note`/`hold_length` into `note_reg` and sets `note_beats`=`hold_length`, with 0 treated as 1. It clears `hit_done`.
- Each `game_frame` increment decrements `note_beats`. When `note_beats` reaches 0, the window closes:
  - If `note_reg`≠0 and `hit_done`=0, it is a miss.
  - A new load is then scheduled.
- Press = any bit of `key_press & ~key_prev` while in PLAY with the window open.
  - Hit: `hit_done`=0, `note_reg`≠0, and the press equals `note_reg` exactly. Then `score` += `note_reg`'s hold length (saturating at 1023), `hit_done`=1, and `hit_pulse` fires.
  - Miss: the press hits a wrong key, extra bits, or a rest (`note_reg`=0), with `hit_done`=0. Then `misses`+1 and `miss_pulse` fires.
  - A press after `hit_done`=1 is ignored.
- Dead cycles: between window close and the next load, the window is closed and presses are ignored.
- Same cycle as a close: a press in the closing cycle is judged first. A hit there suppresses the close miss.
- At most one `misses` increment per cycle.
- End of game:
  - `misses` reaching `MAX_MISSES` → DONE with `won`=0, on the cycle after the increment.
  - `game_frame` reaching `SONG_BEATS` while `misses`<`MAX_MISSES` → DONE with `won`=1.
  - If both happen in the same cycle, the result is lost.
- Arithmetic: `score` and `misses` are unsigned and saturate; they never wrap.

## Timing
- Frame step: the increment edge occurs when the tick counter = `TICKS_PER_BEAT`-1. The new `game_frame` is visible the next cycle, call it N.
- Note load: happens at N+2, allowing for the engine's one-cycle registered index update and its note register.
- First load after `start`: the restart cycle is S, and the load occurs at S+2. `game_frame` = 0 meanwhile, which resets the engine.
- Pulses:
  - `hit_pulse`/`miss_pulse` are registered and assert the cycle after the judging edge, with `score`/`misses` updating on the same cycle.
  - A close-miss pulse is aligned with cycle N.
- `state` changes one cycle after the triggering pulse or condition.
- Synchronous `reset` mid-game wins over every other input. All outputs are at reset values on the following cycle.

## Test plan
Bench parameters: `TICKS_PER_BEAT`=4, `SONG_BEATS`=6, `MAX_MISSES`=3, with a behavioral engine stub that has a 2-cycle note latency.
- Reset, then `start` → `state`=1, and `game_frame` steps 0→1 after 4 cycles and 1→2 after 8. It reaches 6 → `state`=3, `won`=1, `score`=0, `misses`=rest-free note count.
- Correct single-key press on a 2-beat note → one `hit_pulse`, `score`=2. A second press of the same key gives no pulse, and there is no miss at window close.
- Wrong key (bit 3 vs note bit 5), then the correct key → `misses`=1 and `score` += hold. A press during a rest → `misses`+1.
- Three missed notes → `state`=3 with `won`=0 and `misses`=3. `start` then gives `state`=1 and `score`=`misses`=`game_frame`=0.
- `pause` at `game_frame`=2 for 20 cycles, with a key held throughout and across resume → `game_frame` stays 2, and no hit/miss on resume until the key is released and pressed again.
- Press in the same cycle as the window close → hit, no miss. `reset` asserted mid-PLAY → all outputs 0 and `state`=0 the next cycle. `start` and `pause` together in PLAY → restart.
